writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_load_align.sv | 51 +++++
 rtl/writeback_unit.sv | 118 +++++++++++
 tb/tb_writeback_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings and the FIFO entry layout for the writeback unit.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_LINK = 2'b10,
    RES_IMM  = 2'b11
  } res_sel_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  localparam int unsigned MAX_XLEN       = 64;
  localparam int unsigned MAX_REG_ADDR_W = 8;
  localparam int unsigned FIFO_DEPTH     = 2;

  // Entry sized for the widest legal build; narrower builds truncate on read.
  typedef struct packed {
    logic [MAX_XLEN-1:0]       result;
    logic [MAX_REG_ADDR_W-1:0] waddr;
    logic                      we;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load lane selection and sign/zero extension of memory read data.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [31:0]     word_lane;
  logic [XLEN-1:0] fill;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    word_lane = mem_rdata[31:0];
  end

  // Extension is done by OR-ing the lane into a mask of the sign bit, which
  // stays legal when the word lane already fills XLEN.
  always_comb begin
    fill      = '0;
    load_data = '0;
    case (mem_size_e'(mem_size))
      SIZE_BYTE: begin
        fill      = {XLEN{!mem_unsigned && byte_lane[7]}};
        load_data = (fill & ~XLEN'(8'hFF)) | XLEN'(byte_lane);
      end
      SIZE_HALF: begin
        fill      = {XLEN{!mem_unsigned && half_lane[15]}};
        load_data = (fill & ~XLEN'(16'hFFFF)) | XLEN'(half_lane);
      end
      default: begin
        fill      = {XLEN{!mem_unsigned && word_lane[31]}};
        load_data = (fill & ~XLEN'(32'hFFFF_FFFF)) | XLEN'(word_lane);
      end
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: selects/aligns the result and queues it in a 2-entry FIFO
// ahead of the register-file write port. Define WB_RETIRE_COUNT_EN for retire_count.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            res_sel,
  input  logic [XLEN-1:0]       alu_out,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic [XLEN-1:0]       pc_plus4,
  input  logic [XLEN-1:0]       imm,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [1:0]            addr_lo,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic                  rf_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0]           retire_count
`endif
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  logic [1:0]      count;
  wb_entry_t       slot0;
  wb_entry_t       slot1;
  wb_entry_t       new_entry;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] sel_result;
  logic            head_valid;
  logic            push;
  logic            pop;

  wb_load_align #(.XLEN(XLEN)) u_load_align (
    .mem_rdata   (mem_rdata),
    .mem_size    (mem_size),
    .mem_unsigned(mem_unsigned),
    .addr_lo     (addr_lo),
    .load_data   (load_data)
  );

  always_comb begin
    sel_result = alu_out;
    case (res_sel_e'(res_sel))
      RES_ALU:  sel_result = alu_out;
      RES_MEM:  sel_result = load_data;
      RES_LINK: sel_result = pc_plus4;
      RES_IMM:  sel_result = imm;
      default:  sel_result = alu_out;
    endcase
  end

  always_comb begin
    new_entry        = '0;
    new_entry.result = MAX_XLEN'(sel_result);
    new_entry.waddr  = MAX_REG_ADDR_W'(write_reg);
    new_entry.we     = reg_write && (write_reg != '0);
  end

  // Flow control depends only on registered occupancy, never on rf_ready.
  assign in_ready   = (count < FULL);
  assign head_valid = (count != 2'd0);
  assign push       = in_valid && in_ready;
  assign pop        = head_valid && (rf_ready || !slot0.we);

  assign rf_we    = head_valid && slot0.we;
  assign rf_waddr = head_valid ? REG_ADDR_W'(slot0.waddr) : '0;
  assign rf_wdata = head_valid ? XLEN'(slot0.result) : '0;

  // slot0 is always the head; slot1 only holds data when count == 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= new_entry;
          else               slot1 <= new_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Push+pop only happens at count == 1, since full blocks push.
          slot0 <= new_entry;
        end
        default: ;
      endcase
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      retire_q <= '0;
    else if (pop) retire_q <= retire_q + 32'd1;
  end

  assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized and directed bench for writeback_unit against a queue-based model.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  res_sel;
  logic [31:0] alu_out, mem_rdata, pc_plus4, imm;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [1:0]  addr_lo;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic        rf_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
  logic [31:0] exp_cnt = 0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    bit          we;
  } ent_t;
  ent_t q[$];

  writeback_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .res_sel(res_sel), .alu_out(alu_out), .mem_rdata(mem_rdata),
    .pc_plus4(pc_plus4), .imm(imm), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr_lo(addr_lo), .reg_write(reg_write),
    .write_reg(write_reg), .rf_ready(rf_ready), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result the spec's rules say should be written for the current inputs.
  function automatic logic [31:0] model_result();
    longint unsigned v;
    int w, sh;
    case (res_sel)
      2'd0: return alu_out;
      2'd2: return pc_plus4;
      2'd3: return imm;
      default: begin
        if (mem_size == 2'd0)      begin w = 8;  sh = 8 * addr_lo; end
        else if (mem_size == 2'd1) begin w = 16; sh = 16 * (addr_lo / 2); end
        else                       begin w = 32; sh = 0; end
        v = (longint'(mem_rdata) >> sh) & ((64'd1 << w) - 1);
        if (!mem_unsigned && v[w-1]) v = v | (~64'd0 << w);
        return v[31:0];
      end
    endcase
  endfunction

  // Advance one clock; the model steps on the same edge as the DUT.
  task automatic tick();
    bit acc, rel;
    ent_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
`ifdef WB_RETIRE_COUNT_EN
      exp_cnt = 0;
`endif
    end else begin
      acc = in_valid && (q.size() < 2);
      rel = (q.size() > 0) && (rf_ready || !q[0].we);
      e.data = model_result();
      e.addr = write_reg;
      e.we   = reg_write && (write_reg != 0);
      if (rel) void'(q.pop_front());
      if (acc) q.push_back(e);
`ifdef WB_RETIRE_COUNT_EN
      if (rel) exp_cnt++;
`endif
    end
    @(negedge clk);
  endtask

  // Single compare point, away from the active edge.
  always @(negedge clk) begin
    bit ew;
    ew = (q.size() > 0) && q[0].we;
    check("in_ready", in_ready, q.size() < 2);
    check("rf_we", rf_we, ew);
    if (ew) begin
      check("rf_waddr", rf_waddr, q[0].addr);
      check("rf_wdata", rf_wdata, q[0].data);
    end
`ifdef WB_RETIRE_COUNT_EN
    check("retire_count", retire_count, exp_cnt);
`endif
  end

  task automatic offer(input logic [1:0] sel, input logic [31:0] val,
                       input logic rw, input logic [4:0] wr);
    in_valid = 1'b1; res_sel = sel; reg_write = rw; write_reg = wr;
    alu_out = val; pc_plus4 = val; imm = val; mem_rdata = val;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; res_sel = 0; alu_out = 0; mem_rdata = 0;
    pc_plus4 = 0; imm = 0; mem_size = 0; mem_unsigned = 0; addr_lo = 0;
    reg_write = 0; write_reg = 0; rf_ready = 1;
    #2;
    check("reset_rf_we", rf_we, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_rf_wdata", rf_wdata, 0);
    check("reset_rf_waddr", rf_waddr, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // ALU path with one-cycle latency.
    offer(2'b00, 32'h0000_1234, 1, 5'd3);
    tick(); in_valid = 0;
    check("alu_we", rf_we, 1);
    check("alu_waddr", rf_waddr, 3);
    check("alu_wdata", rf_wdata, 32'h0000_1234);
    tick();

    // Signed then unsigned byte load from lane 2.
    offer(2'b01, 32'h80FF_7F01, 1, 5'd9);
    mem_size = 2'b00; addr_lo = 2'd2; mem_unsigned = 0;
    tick(); in_valid = 0;
    check("lb_signed", rf_wdata, 32'hFFFF_FFFF);
    tick();
    offer(2'b01, 32'h80FF_7F01, 1, 5'd9); mem_unsigned = 1;
    tick(); in_valid = 0;
    check("lb_unsigned", rf_wdata, 32'h0000_00FF);
    tick();
    offer(2'b01, 32'h80FF_7F01, 1, 5'd9); mem_size = 2'b01; addr_lo = 2'd3; mem_unsigned = 0;
    tick(); in_valid = 0;
    check("lh_signed_hi", rf_wdata, 32'hFFFF_80FF);
    tick();

    // Backpressure: three back-to-back offers with the port busy.
    rf_ready = 0;
    offer(2'b00, 32'hA, 1, 5'd1); tick();
    offer(2'b00, 32'hB, 1, 5'd2); tick();
    check("bp_full", in_ready, 0);
    offer(2'b00, 32'hC, 1, 5'd4); tick(); tick();
    check("bp_still_full", in_ready, 0);
    check("bp_head_a", rf_wdata, 32'hA);
    rf_ready = 1; tick();
    check("bp_head_b", rf_wdata, 32'hB);
    check("bp_ready_back", in_ready, 1);
    tick(); in_valid = 0;
    check("bp_head_c", rf_wdata, 32'hC);
    check("bp_c_addr", rf_waddr, 4);
    tick();

    // r0 and non-writing entries retire without a write.
    rf_ready = 0;
    offer(2'b00, 32'h55, 1, 5'd0); tick();
    check("r0_no_we", rf_we, 0);
    offer(2'b00, 32'h66, 0, 5'd7); tick(); in_valid = 0;
    check("nw_no_we", rf_we, 0);
    check("nw_ready", in_ready, 1);
    tick();
    check("nw_drained", in_ready, 1);
    rf_ready = 1;

    // Asynchronous reset with two entries queued.
    rf_ready = 0;
    offer(2'b00, 32'h77, 1, 5'd5); tick();
    offer(2'b00, 32'h88, 1, 5'd6); tick(); in_valid = 0;
    check("pre_rst_full", in_ready, 0);
    #2 rst = 1'b1;
    q.delete();
`ifdef WB_RETIRE_COUNT_EN
    exp_cnt = 0;
`endif
    #1;
    check("rst_async_we", rf_we, 0);
    check("rst_async_ready", in_ready, 1);
    check("rst_async_wdata", rf_wdata, 0);
    tick();
    rst = 1'b0; rf_ready = 1;
    repeat (3) begin
      tick();
      check("post_rst_no_we", rf_we, 0);
    end

`ifdef WB_RETIRE_COUNT_EN
    force dut.retire_q = 32'hFFFF_FFFF;
    #1 release dut.retire_q;
    exp_cnt = 32'hFFFF_FFFF;
    offer(2'b00, 32'h1, 0, 5'd0); tick(); in_valid = 0; tick();
    check("retire_wrap", retire_count, 32'h0);
`endif

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      res_sel      = 2'($urandom_range(0, 3));
      alu_out      = $urandom; mem_rdata = $urandom;
      pc_plus4     = $urandom; imm = $urandom;
      mem_size     = 2'($urandom_range(0, 3));
      mem_unsigned = 1'($urandom_range(0, 1));
      addr_lo      = 2'($urandom_range(0, 3));
      reg_write    = ($urandom_range(0, 4) != 0);
      write_reg    = 5'($urandom_range(0, 31));
      rf_ready     = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
